// File: rtl/dp_pkg.sv
// Shared constants, FSM state type and operand-slicing helper for the dot product engine.
package dp_pkg;

    localparam int unsigned DW      = 8;
    localparam int unsigned NUM_VEC = 4;
    localparam int unsigned VEC_LEN = 4;
    localparam int unsigned ACC_W   = 18;
    localparam int unsigned SHIFT   = 4;

    localparam int unsigned DATA_W = NUM_VEC * VEC_LEN * DW;
    localparam int unsigned WGT_W  = VEC_LEN * DW;
    localparam int unsigned CNT_W  = $clog2(NUM_VEC * VEC_LEN);
    localparam int unsigned K_W    = $clog2(VEC_LEN);
    localparam int unsigned SEL_W  = $clog2(NUM_VEC);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StPost
    } state_e;

    // Flat index v*VEC_LEN+k maps straight onto the packed data word; weights reuse it with v=0.
    function automatic logic [DW-1:0] elem(input logic [DATA_W-1:0] bus,
                                           input logic [CNT_W-1:0]  idx);
        return bus[idx*DW +: DW];
    endfunction

endpackage

// File: rtl/requant_relu.sv
// ReLU, arithmetic right shift and unsigned saturation of one accumulator lane.
module requant_relu #(
    parameter int unsigned ACC_W = 18,
    parameter int unsigned SHIFT = 4,
    parameter int unsigned OUT_W = 8
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic        [OUT_W-1:0] res_o
);

    logic signed [ACC_W-1:0] shifted;

    assign shifted = acc_i >>> SHIFT;

    always_comb begin
        res_o = '0;
        if (acc_i[ACC_W-1] || (acc_i == '0)) begin
            res_o = '0;
        end else if (|shifted[ACC_W-1:OUT_W]) begin
            res_o = '1;
        end else begin
            res_o = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/dot_product_engine.sv
// Four int8 dot products of length four via one shared MAC, requantised to uint8 lanes.
module dot_product_engine #(
    parameter int unsigned NUM_VEC = dp_pkg::NUM_VEC,
    parameter int unsigned VEC_LEN = dp_pkg::VEC_LEN,
    parameter int unsigned DW      = dp_pkg::DW,
    parameter int unsigned ACC_W   = dp_pkg::ACC_W,
    parameter int unsigned SHIFT   = dp_pkg::SHIFT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [VEC_LEN*DW-1:0]      weights,
    input  logic [NUM_VEC*VEC_LEN*DW-1:0] data,
    output logic                       busy,
    output logic                       done,
    output logic                       result_valid,
    output logic [NUM_VEC*8-1:0]       result,
    input  logic [$clog2(NUM_VEC)-1:0] sel,
    output logic [7:0]                 res_byte
);

    import dp_pkg::*;

    state_e state_q, state_d;

    logic [WGT_W-1:0]        weights_q, weights_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q [NUM_VEC];
    logic signed [ACC_W-1:0] acc_d [NUM_VEC];
    logic [NUM_VEC*8-1:0]    result_q, result_d;
    logic                    result_valid_q, result_valid_d;
    logic                    done_q, done_d;

    logic [NUM_VEC*8-1:0]    lane_res;
    logic signed [DW-1:0]    x_op, w_op;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic [CNT_W-K_W-1:0]    lane;
    logic                    last;

    assign lane = cnt_q[CNT_W-1:K_W];
    assign last = (cnt_q == '1);

    // Single shared multiplier; k picks the weight, the full counter picks the data element.
    assign x_op     = elem(data_q, cnt_q);
    assign w_op     = elem({{(DATA_W-WGT_W){1'b0}}, weights_q},
                           {{(CNT_W-K_W){1'b0}}, cnt_q[K_W-1:0]});
    assign prod     = x_op * w_op;
    assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};

    for (genvar g = 0; g < NUM_VEC; g++) begin : g_lane
        requant_relu #(
            .ACC_W(ACC_W),
            .SHIFT(SHIFT),
            .OUT_W(8)
        ) u_requant_relu (
            .acc_i(acc_q[g]),
            .res_o(lane_res[8*g +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad:  state_d = StRun;
            StRun:   if (last) state_d = StPost;
            StPost:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

    always_comb begin
        weights_d      = weights_q;
        data_d         = data_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        done_d         = 1'b0;
        case (state_q)
            StLoad: begin
                weights_d      = weights;
                data_d         = data;
                cnt_d          = '0;
                result_valid_d = 1'b0;
                for (int i = 0; i < NUM_VEC; i++) acc_d[i] = '0;
            end
            StRun: begin
                acc_d[lane] = acc_q[lane] + prod_ext;
                cnt_d       = cnt_q + 1'b1;
            end
            StPost: begin
                result_d       = lane_res;
                result_valid_d = 1'b1;
                done_d         = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            weights_q      <= '0;
            data_q         <= '0;
            cnt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            for (int i = 0; i < NUM_VEC; i++) acc_q[i] <= '0;
        end else begin
            weights_q      <= weights_d;
            data_q         <= data_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            done_q         <= done_d;
            for (int i = 0; i < NUM_VEC; i++) acc_q[i] <= acc_d[i];
        end
    end

    assign done         = done_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign res_byte     = result_q[{sel, 3'b000} +: 8];

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed-vector bench for dot_product_engine: latency, requantisation, snapshot and reset.
module tb_dot_product_engine;

    logic         clk;
    logic         rst;
    logic         start;
    logic [31:0]  weights;
    logic [127:0] data;
    logic         busy;
    logic         done;
    logic         result_valid;
    logic [31:0]  result;
    logic [1:0]   sel;
    logic [7:0]   res_byte;

    int checks = 0;
    int errors = 0;

    dot_product_engine u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .weights     (weights),
        .data        (data),
        .busy        (busy),
        .done        (done),
        .result_valid(result_valid),
        .result      (result),
        .sel         (sel),
        .res_byte    (res_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench 1 time unit after the edge where done first rose; lat = -1 on timeout.
    task automatic run_op(input logic [31:0] w, input logic [127:0] d, output int lat);
        weights = w;
        data    = d;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        weights = '0;
        data = '0;
        sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, result_valid} !== 3'b000) begin
            $display("FAIL reset_flags: got busy/done/valid=%b, want 000", {busy, done, result_valid});
            errors++;
        end
        checks++;
        if (result !== 32'h0 || res_byte !== 8'h00) begin
            $display("FAIL reset_result: got result=%h res_byte=%h, want 0/0", result, res_byte);
            errors++;
        end
    endtask

    task automatic test_basic;
        int lat;
        run_op(32'h01010101, {16{8'h10}}, lat);
        checks++;
        if (lat !== 18) begin
            $display("FAIL basic_latency: got %0d, want 18", lat);
            errors++;
        end
        checks++;
        if (result !== 32'h04040404 || result_valid !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL basic_result: got result=%h valid=%b busy=%b, want 04040404/1/0",
                     result, result_valid, busy);
            errors++;
        end
        for (int s = 0; s < 4; s++) begin
            sel = s[1:0];
            #1;
            checks++;
            if (res_byte !== 8'h04) begin
                $display("FAIL basic_res_byte sel=%0d: got %h, want 04", s, res_byte);
                errors++;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || result !== 32'h04040404) begin
            $display("FAIL basic_done_pulse: got done=%b result=%h, want 0/04040404", done, result);
            errors++;
        end
    endtask

    task automatic test_reset_during_run;
        int dones = 0;
        weights = 32'h01010101;
        data = {16{8'h10}};
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL rstrun_busy_before: got %b, want 1", busy);
            errors++;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, result_valid} !== 3'b000 || result !== 32'h0) begin
            $display("FAIL rstrun_state: got busy/done/valid=%b result=%h, want 000/0",
                     {busy, done, result_valid}, result);
            errors++;
        end
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            $display("FAIL rstrun_no_done: got %0d done pulses, want 0", dones);
            errors++;
        end
    endtask

    task automatic test_relu_sat;
        int lat;
        run_op(32'hFFFFFFFF, {16{8'h10}}, lat);
        checks++;
        if (lat !== 18 || result !== 32'h00000000 || result_valid !== 1'b1) begin
            $display("FAIL relu_negative: got lat=%0d result=%h valid=%b, want 18/00000000/1",
                     lat, result, result_valid);
            errors++;
        end
        run_op(32'h7F7F7F7F, {16{8'h7F}}, lat);
        checks++;
        if (lat !== 18 || result !== 32'hFFFFFFFF) begin
            $display("FAIL saturate: got lat=%0d result=%h, want 18/FFFFFFFF", lat, result);
            errors++;
        end
    endtask

    task automatic test_lane_isolation;
        int lat;
        run_op(32'h04030201, 128'h00000000_10101010_00000000_00000000, lat);
        checks++;
        if (lat !== 18 || result !== 32'h000A0000) begin
            $display("FAIL lane_iso_result: got lat=%0d result=%h, want 18/000A0000", lat, result);
            errors++;
        end
        sel = 2'd2;
        #1;
        checks++;
        if (res_byte !== 8'h0A) begin
            $display("FAIL lane_iso_sel2: got %h, want 0A", res_byte);
            errors++;
        end
        sel = 2'd0;
        #1;
        checks++;
        if (res_byte !== 8'h00) begin
            $display("FAIL lane_iso_sel0: got %h, want 00", res_byte);
            errors++;
        end
    endtask

    task automatic test_snapshot;
        int dones = 0;
        int lat = -1;
        weights = 32'h01010101;
        data = {16{8'h10}};
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                dones++;
                if (lat < 0) lat = i;
            end
            if (i == 5) begin
                data  = {16{8'h7F}};
                start = 1'b1;
            end
        end
        checks++;
        if (dones !== 1 || lat !== 18) begin
            $display("FAIL snapshot_done: got %0d pulses first at %0d, want 1 at 18", dones, lat);
            errors++;
        end
        checks++;
        if (result !== 32'h04040404) begin
            $display("FAIL snapshot_result: got %h, want 04040404", result);
            errors++;
        end
    endtask

    task automatic test_back_to_back;
        int first = -1;
        int second = -1;
        weights = 32'h01010101;
        data = {16{8'h10}};
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            if (i == 19) begin
                checks++;
                if (busy !== 1'b1 || result_valid !== 1'b1) begin
                    $display("FAIL b2b_e19: got busy=%b valid=%b, want 1/1", busy, result_valid);
                    errors++;
                end
                start   = 1'b0;
                weights = 32'hFFFFFFFF;
            end
            if (i == 20) begin
                checks++;
                if (result_valid !== 1'b0) begin
                    $display("FAIL b2b_valid_drop: got %b, want 0", result_valid);
                    errors++;
                end
            end
        end
        checks++;
        if (first !== 18 || second !== 37) begin
            $display("FAIL b2b_latency: got done at %0d and %0d, want 18 and 37", first, second);
            errors++;
        end
        checks++;
        if (result !== 32'h00000000 || result_valid !== 1'b1) begin
            $display("FAIL b2b_result: got result=%h valid=%b, want 00000000/1", result, result_valid);
            errors++;
        end
    endtask

    task automatic test_mid_run_reset;
        int dones = 0;
        int lat;
        weights = 32'h7F7F7F7F;
        data = {16{8'h7F}};
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 32'h0) begin
            $display("FAIL midrst_state: got busy=%b valid=%b result=%h, want 0/0/0",
                     busy, result_valid, result);
            errors++;
        end
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            $display("FAIL midrst_no_done: got %0d done pulses, want 0", dones);
            errors++;
        end
        run_op(32'h04030201, 128'h00000000_10101010_00000000_00000000, lat);
        checks++;
        if (lat !== 18 || result !== 32'h000A0000) begin
            $display("FAIL midrst_rerun: got lat=%0d result=%h, want 18/000A0000", lat, result);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_during_run();
        test_relu_sat();
        test_lane_isolation();
        test_snapshot();
        test_back_to_back();
        test_mid_run_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
